// File: rtl/mac_acc_pkg.sv
// Shared constants and state encoding for the nibble-serial MAC accumulator.
package mac_acc_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned IN_W_DEF  = 8;
  localparam int unsigned ACC_W_DEF = 16;
  localparam int unsigned NIBBLES   = ACC_W_DEF / NIB_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mac_operand_ext.sv
// Extends the multiplier product to accumulator width.
// MAC_ACC_SIGNED_EN selects sign extension; otherwise zero extension.
module mac_operand_ext #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic [IN_W-1:0]  i_data,
  output logic [ACC_W-1:0] o_ext_c
);

`ifdef MAC_ACC_SIGNED_EN
  assign o_ext_c = ACC_W'($signed(i_data));
`else
  assign o_ext_c = ACC_W'(i_data);
`endif

endmodule

// File: rtl/mac_nibble_accumulator.sv
// Nibble-serial accumulator driving an external 4-bit adder slice, one nibble per cycle.
// MAC_ACC_SIGNED_EN selects signed operand extension and signed overflow detection.
module mac_nibble_accumulator
  import mac_acc_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             clear,
  output logic [NIB_W-1:0] adder_a,
  output logic [NIB_W-1:0] adder_b,
  output logic             adder_cin,
  input  logic [NIB_W-1:0] adder_sum,
  input  logic             adder_cout,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic             overflow
);

  localparam int unsigned NIB_CNT = ACC_W / NIB_W;
  localparam int unsigned CNT_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_nib;
  logic               r_carry;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_op;
  logic               r_ovf;
  logic [ACC_W-1:0]   w_ext;
  logic               w_last;
  logic               w_ovf_new;
  logic               w_accept;

  mac_operand_ext #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_ext (
    .i_data  (in_data),
    .o_ext_c (w_ext)
  );

  assign w_last   = (r_nib == CNT_W'(NIB_CNT - 1));
  assign w_accept = (r_state == IDLE) && in_valid;

`ifdef MAC_ACC_SIGNED_EN
  // r_acc MSB is still the pre-add value while the last nibble is in flight
  assign w_ovf_new = (r_op[ACC_W-1] == r_acc[ACC_W-1]) &&
                     (adder_sum[NIB_W-1] != r_acc[ACC_W-1]);
`else
  assign w_ovf_new = adder_cout;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and adder-slice drive
  always_comb begin
    w_state_nxt = r_state;
    adder_a     = '0;
    adder_b     = '0;
    adder_cin   = 1'b0;
    unique case (r_state)
      IDLE: if (in_valid) w_state_nxt = ADD;
      ADD: begin
        for (int k = 0; k < NIB_CNT; k++) begin
          if (r_nib == CNT_W'(k)) begin
            adder_a = r_acc[k*NIB_W +: NIB_W];
            adder_b = r_op[k*NIB_W +: NIB_W];
          end
        end
        adder_cin = r_carry;
        if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulator datapath: operand capture, nibble write-back, carry and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nib   <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_op    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        if (clear) begin
          r_acc <= '0;
          r_ovf <= 1'b0;
        end
        if (w_accept) begin
          r_op    <= w_ext;
          r_nib   <= '0;
          r_carry <= 1'b0;
        end
      end else if (r_state == ADD) begin
        for (int k = 0; k < NIB_CNT; k++) begin
          if (r_nib == CNT_W'(k)) r_acc[k*NIB_W +: NIB_W] <= adder_sum;
        end
        r_carry <= adder_cout;
        r_nib   <= r_nib + CNT_W'(1);
        if (w_last) r_ovf <= r_ovf | w_ovf_new;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign acc_out   = r_acc;
  assign overflow  = r_ovf;

endmodule
